ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the send direction of the existing ps2_keyboard receive path.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
//   Sends one command byte to the PS/2 device: inhibit clock, assert start bit,
//   release clock, then shift data/parity/stop out on the device's falling clock
//   edges and sample the device ACK. The lines are open-drain; this block only
//   drives active-high pull-low enables.
// Ports:
//   clk, rstn            system clock, asynchronous active-low reset
//   tx_data[7:0]         byte to send, captured when tx_start is accepted
//   tx_start             1-cycle request, accepted only in IDLE
//   ps2_clk_in/data_in   raw (asynchronous) PS/2 line levels
//   ps2_clk_oe/data_oe   1 = pull the line low, 0 = release
//   tx_busy              frame in flight (accepted start through tx_done cycle)
//   tx_done              1-cycle pulse at the end of every accepted frame
//   tx_err, tx_ack       qualified by tx_done
// Handshake: tx_start is a single-cycle request with no ready; it is taken only
//   while tx_busy is low and dropped otherwise. Every taken request produces
//   exactly one tx_done pulse, with tx_ack/tx_err valid in that same cycle.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_ack
);

    localparam int WAIT_MAX = (INHIBIT_CYCLES > 16) ? INHIBIT_CYCLES : 16;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W    = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_DATA_LOW,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    // ---------------- input synchronisers and clock glitch filter ----------------
    // Sync flops reset to 1 (idle bus level) so that leaving reset never
    // fakes a falling edge.
    logic             clk_s1, clk_s2, dat_s1, dat_s2;
    logic             filt_clk, filt_prev;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            clk_s1    <= ps2_clk_in;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data_in;
            dat_s2    <= dat_s1;
            filt_prev <= filt_clk;
            // flt_cnt counts consecutive samples that disagree with filt_clk;
            // the FILTER_LEN-th disagreeing sample flips the filtered level.
            if (clk_s2 != filt_clk) begin
                if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    flt_cnt  <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FLT_W'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;

    // ---------------- FSM ----------------
    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [TO_W-1:0]   to_cnt, to_d;
    logic [3:0]        bit_idx, bit_d;
    logic [8:0]        frame, frame_d;    // {parity, data}
    logic              data_drv, drv_d;   // pull-low request for current bit
    logic              ack_q, ack_d;
    logic              to_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            to_cnt   <= '0;
            bit_idx  <= '0;
            frame    <= '0;
            data_drv <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            to_cnt   <= to_d;
            bit_idx  <= bit_d;
            frame    <= frame_d;
            data_drv <= drv_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        to_d        = to_cnt;
        bit_d       = bit_idx;
        frame_d     = frame;
        drv_d       = data_drv;
        ack_d       = ack_q;
        to_hit      = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    frame_d = {~^tx_data, tx_data};   // odd parity
                    ack_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DATA_LOW;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DATA_LOW: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                if (cnt == CNT_W'(15)) begin
                    cnt_d   = '0;
                    to_d    = '0;
                    bit_d   = '0;
                    drv_d   = 1'b1;   // start bit stays on the line after clock release
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_SEND, S_ACK, S_WAIT_IDLE: begin
                to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
                to_d   = to_cnt + TO_W'(1);
                if (to_hit) begin
                    // Lines are released in this very cycle (data_oe stays 0).
                    ack_d   = 1'b0;
                    drv_d   = 1'b0;
                    state_d = S_DONE;
                end else if (state == S_SEND) begin
                    ps2_data_oe = data_drv;
                    if (fall) begin
                        if (bit_idx == 4'd9) begin
                            drv_d   = 1'b0;   // stop bit: released line
                            state_d = S_ACK;
                        end else begin
                            drv_d = ~frame[bit_idx];
                            bit_d = bit_idx + 4'd1;
                        end
                    end
                end else if (state == S_ACK) begin
                    if (fall) begin
                        ack_d   = ~dat_s2;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    if (filt_clk && dat_s2) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_busy = (state != S_IDLE);
    assign tx_done = (state == S_DONE);
    assign tx_err  = (state == S_DONE) & ~ack_q;
    assign tx_ack  = (state == S_DONE) & ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INHIBIT = 60;
    localparam int TIMEOUT = 4000;
    localparam int FILT    = 8;
    localparam int HP      = 50;     // device BFM half clock period in clk cycles
    localparam int WAIT_MAX = 3000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_busy, tx_done, tx_err, tx_ack;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    int pass_cnt = 0;
    int total_cnt = 0;

    int   done_cnt = 0;
    logic last_ack = 1'b0;
    logic last_err = 1'b0;

    // open-drain bus: line is low if either side pulls it
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN(FILT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .tx_ack(tx_ack)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- done monitor ----------------
    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            last_ack <= tx_ack;
            last_err <= tx_err;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device side: wait for the host request, then generate n_clk clock pulses,
    // sampling the line before each rising edge; the 11th pulse carries the ACK.
    task automatic device_rx(input int n_clk, input bit ack_en, input int glitch_after,
                             output logic [9:0] bits, output bit ok);
        int w;
        bits = '0;
        ok   = 1'b1;
        w    = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        if (w >= WAIT_MAX) begin
            ok = 1'b0;
            return;
        end
        repeat (HP) @(negedge clk);
        for (int i = 0; i < n_clk && i < 11; i++) begin
            if (i == 10) begin
                dev_data = ack_en ? 1'b0 : 1'b1;
                repeat (HP / 2) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HP) @(negedge clk);
            if (i < 10) bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (HP) @(negedge clk);
            if (i == 10) dev_data = 1'b1;
            if (i == glitch_after) begin
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HP) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(input int base);
        int w;
        w = 0;
        while (done_cnt == base && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn     = 1'b0;
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); else pass_cnt++;
        total_cnt++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else pass_cnt++;
        total_cnt++; if (tx_done !== 1'b0) $display("FAIL reset_done got %b want 0", tx_done); else pass_cnt++;
        total_cnt++; if (tx_err !== 1'b0) $display("FAIL reset_err got %b want 0", tx_err); else pass_cnt++;
        total_cnt++; if (tx_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", tx_ack); else pass_cnt++;
        tx_start = 1'b0;
        rstn     = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame(input string name, input logic [7:0] b, input logic exp_par,
                              input bit ack_en, input logic exp_ack, input logic exp_err,
                              input int glitch_after);
        int base;
        logic [9:0] bits;
        bit ok;
        base = done_cnt;
        start_tx(b);
        total_cnt++; if (tx_busy !== 1'b1) $display("FAIL %s busy_start got %b want 1", name, tx_busy); else pass_cnt++;
        device_rx(11, ack_en, glitch_after, bits, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL %s request_seen got %b want 1", name, ok); else pass_cnt++;
        total_cnt++; if (bits[7:0] !== b) $display("FAIL %s data got %h want %h", name, bits[7:0], b); else pass_cnt++;
        total_cnt++; if (bits[8] !== exp_par) $display("FAIL %s parity got %b want %b", name, bits[8], exp_par); else pass_cnt++;
        total_cnt++; if (bits[9] !== 1'b1) $display("FAIL %s stop got %b want 1", name, bits[9]); else pass_cnt++;
        wait_done(base);
        total_cnt++; if (done_cnt - base !== 1) $display("FAIL %s done_pulses got %0d want 1", name, done_cnt - base); else pass_cnt++;
        total_cnt++; if (last_ack !== exp_ack) $display("FAIL %s ack got %b want %b", name, last_ack, exp_ack); else pass_cnt++;
        total_cnt++; if (last_err !== exp_err) $display("FAIL %s err got %b want %b", name, last_err, exp_err); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL %s busy_end got %b want 0", name, tx_busy); else pass_cnt++;
    endtask

    task automatic test_sequencing();
        int n1, n2, base;
        logic [9:0] bits;
        bit ok;
        base = done_cnt;
        start_tx(8'h00);
        n1 = 0;
        while (ps2_clk_oe && !ps2_data_oe && n1 < WAIT_MAX) begin
            n1++;
            @(negedge clk);
        end
        n2 = 0;
        while (ps2_clk_oe && ps2_data_oe && n2 < WAIT_MAX) begin
            n2++;
            @(negedge clk);
        end
        total_cnt++; if (n1 !== INHIBIT) $display("FAIL seq_inhibit got %0d want %0d", n1, INHIBIT); else pass_cnt++;
        total_cnt++; if (n2 !== 16) $display("FAIL seq_data_low got %0d want 16", n2); else pass_cnt++;
        device_rx(11, 1'b1, -1, bits, ok);
        total_cnt++; if (bits[7:0] !== 8'h00) $display("FAIL seq_data got %h want 00", bits[7:0]); else pass_cnt++;
        total_cnt++; if (bits[8] !== 1'b1) $display("FAIL seq_parity got %b want 1", bits[8]); else pass_cnt++;
        wait_done(base);
        total_cnt++; if (last_ack !== 1'b1 || last_err !== 1'b0) $display("FAIL seq_result got ack=%b err=%b want ack=1 err=0", last_ack, last_err); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int w, n;
        start_tx(8'hF4);
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (!tx_done && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        total_cnt++; if (n !== TIMEOUT) $display("FAIL timeout_cycles got %0d want %0d", n, TIMEOUT); else pass_cnt++;
        total_cnt++; if (tx_err !== 1'b1) $display("FAIL timeout_err got %b want 1", tx_err); else pass_cnt++;
        total_cnt++; if (tx_ack !== 1'b0) $display("FAIL timeout_ack got %b want 0", tx_ack); else pass_cnt++;
        total_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL timeout_oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL timeout_busy got %b want 0", tx_busy); else pass_cnt++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int base;
        logic [9:0] bits;
        bit ok;
        base = done_cnt;
        start_tx(8'hF4);
        repeat (5) @(negedge clk);
        start_tx(8'h11);           // lands in INHIBIT
        device_rx(11, 1'b1, -1, bits, ok);
        total_cnt++; if (bits[7:0] !== 8'hF4) $display("FAIL ignore_data got %h want f4", bits[7:0]); else pass_cnt++;
        wait_done(base);
        total_cnt++; if (done_cnt - base !== 1) $display("FAIL ignore_done_pulses got %0d want 1", done_cnt - base); else pass_cnt++;
        repeat (100) @(negedge clk);
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL ignore_no_second_frame got busy=%b want 0", tx_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        bit ok;
        start_tx(8'hF4);
        device_rx(4, 1'b1, -1, bits, ok);
        dev_clk = 1'b0;            // fall for bit 4
        repeat (HP / 2) @(negedge clk);
        total_cnt++; if (tx_busy !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", tx_busy); else pass_cnt++;
        #2;
        rstn = 1'b0;
        #1;
        total_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL rstmid_oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", tx_busy); else pass_cnt++;
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_frame("f4_ack", 8'hF4, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        test_frame("ff_ack", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        test_sequencing();
        test_timeout();
        test_frame("a5_noack", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        test_ignore_start();
        test_frame("glitch", 8'hF4, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        test_reset_mid_frame();
        test_frame("after_reset", 8'hF4, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
